// File: rtl/div_iter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : div_iter_pkg
//  Description : Shared definitions for the iterative divider: state
//                encodings, handshake levels and reset level.
//  Revision    : 1.0  initial release
// ============================================================================
package div_iter_pkg;

  // Divider FSM state encodings
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Reset level
  localparam logic RST_ENABLE           = 1'b1;

  // Result handshake levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Request handshake levels
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : div_iter
//  Description : Multi-cycle restoring divider, signed or unsigned. One
//                quotient bit per cycle; result packed as {remainder,
//                quotient}. Divide-by-zero returns zero after one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  // Iteration counter width follows the operand width
  localparam int               CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  // Registered state
  div_state_e           state,    state_nx;
  logic [CW-1:0]        cnt,      cnt_nx;
  logic [2*WIDTH:0]     work,     work_nx;
  logic [WIDTH-1:0]     divisor,  divisor_nx;
  logic                 neg_quo,  neg_quo_nx;
  logic                 neg_rem,  neg_rem_nx;
  logic [2*WIDTH-1:0]   result_nx;
  logic                 ready_nx;

  // Datapath helpers
  logic [WIDTH:0]       trial_sub;
  logic [WIDTH-1:0]     abs_dividend;
  logic [WIDTH-1:0]     abs_divisor;
  logic                 in_dvd_neg;
  logic                 in_dsr_neg;
  logic [WIDTH-1:0]     raw_quo;
  logic [WIDTH-1:0]     raw_rem;
  logic [WIDTH-1:0]     fix_quo;
  logic [WIDTH-1:0]     fix_rem;

  // Operand magnitudes, trial subtraction and sign-corrected result
  always_comb begin
    in_dvd_neg   = signed_div_i & opdata1_i[WIDTH-1];
    in_dsr_neg   = signed_div_i & opdata2_i[WIDTH-1];
    abs_dividend = in_dvd_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    abs_divisor  = in_dsr_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    // Extra top bit acts as the borrow: set means partial remainder < divisor
    trial_sub    = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    raw_quo      = work[WIDTH-1:0];
    raw_rem      = work[2*WIDTH:WIDTH+1];
    // Most-negative / -1 wraps naturally back to most-negative here
    fix_quo      = neg_quo ? (~raw_quo + 1'b1) : raw_quo;
    fix_rem      = neg_rem ? (~raw_rem + 1'b1) : raw_rem;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    work_nx    = work;
    divisor_nx = divisor;
    neg_quo_nx = neg_quo;
    neg_rem_nx = neg_rem;
    result_nx  = '0;
    ready_nx   = DIV_RESULT_NOT_READY;

    case (state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          divisor_nx = abs_divisor;
          neg_quo_nx = in_dvd_neg ^ in_dsr_neg;
          neg_rem_nx = in_dvd_neg;
          cnt_nx     = '0;
          if (opdata2_i == '0) begin
            state_nx = DIV_BY_ZERO;
            work_nx  = '0;
          end else begin
            state_nx = DIV_ON;
            work_nx  = {{WIDTH{1'b0}}, abs_dividend, 1'b0};
          end
        end
      end

      DIV_BY_ZERO: begin
        work_nx = '0;
        cnt_nx  = '0;
        if (annul_i) begin
          state_nx = DIV_FREE;
        end else begin
          state_nx = DIV_END;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_nx = DIV_FREE;
          work_nx  = '0;
          cnt_nx   = '0;
        end else begin
          if (trial_sub[WIDTH]) begin
            work_nx = {work[2*WIDTH-1:0], 1'b0};
          end else begin
            work_nx = {trial_sub[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
          end
          cnt_nx = cnt + CNT_ONE;
          if (cnt == LAST_CNT) begin
            state_nx = DIV_END;
          end
        end
      end

      DIV_END: begin
        if (start_i == DIV_START) begin
          ready_nx  = DIV_RESULT_READY;
          result_nx = {fix_rem, fix_quo};
        end else begin
          state_nx = DIV_FREE;
          work_nx  = '0;
          cnt_nx   = '0;
        end
      end

      default: begin
        state_nx = DIV_FREE;
        work_nx  = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  // State and output registers; reset overrides every other input
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      work     <= work_nx;
      divisor  <= divisor_nx;
      neg_quo  <= neg_quo_nx;
      neg_rem  <= neg_rem_nx;
      result_o <= result_nx;
      ready_o  <= ready_nx;
    end
  end

endmodule : div_iter
`default_nettype wire

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 4..64).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port signed_div_i  input  1  1 = signed divide, 0 = unsigned divide.
REQ-005 SHALL have port opdata1_i  input  WIDTH  dividend.
REQ-006 SHALL have port opdata2_i  input  WIDTH  divisor.
REQ-007 SHALL have port start_i  input  1  request; held high until ready_o seen.
REQ-008 SHALL have port annul_i  input  1  cancel in-flight divide (pipeline flush).
REQ-009 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}.
REQ-010 SHALL have port ready_o  output  1  result_o valid.

Function
REQ-011 SHALL implement four states: FREE, BYZERO, ON, END.
REQ-012 In FREE with start_i=1 and annul_i=0, SHALL latch opdata1_i, opdata2_i and signed_div_i; later operand changes have no effect.
REQ-013 Transition from FREE: divisor == 0 -> BYZERO; otherwise -> ON with iteration counter = 0.
REQ-014 In FREE, start_i=1 with annul_i=1 SHALL be ignored.
REQ-015 Signed mode SHALL divide absolute values, then negate quotient if operand signs differ and negate remainder if dividend negative (quotient truncates toward zero, remainder takes dividend sign).
REQ-016 ON SHALL produce one quotient bit per cycle by restoring shift/subtract on a (2*WIDTH+1)-bit working register; exactly WIDTH cycles in ON, then -> END.
REQ-017 BYZERO SHALL last one cycle, then -> END with result_o = 0.
REQ-018 Latency: for a request accepted at edge k, ready_o SHALL be 1 after edge k+WIDTH+1 (nonzero divisor) or after edge k+2 (zero divisor).
REQ-019 In END, ready_o SHALL be 1 and result_o stable; state SHALL stay END while start_i=1.
REQ-020 In END with start_i=0, SHALL go to FREE with ready_o=0 and result_o=0 after the next edge.
REQ-021 In ON or BYZERO, annul_i=1 SHALL force FREE at the next edge, with ready_o=0 and result_o=0; no result is produced.
REQ-022 Signed overflow (most-negative / -1) SHALL return quotient = most-negative value and remainder = 0; no error flag.
REQ-023 Outside END, ready_o SHALL be 0 and result_o SHALL be 0.

Reset
REQ-024 rst=1 at an edge SHALL force FREE, counter 0, working register 0, ready_o 0, result_o 0 in any state, including mid-ON; rst takes priority over annul_i and start_i.
REQ-025 A request held on start_i across reset release SHALL be accepted at the first edge with rst=0.

Structure
REQ-026 State encodings (DivFree, DivByZero, DivOn, DivEnd) and the macros DivResultReady/NotReady and DivStart/Stop SHALL live in the shared defines header, alongside RstEnable and ZeroWord.
REQ-027 The counter SHALL be $clog2(WIDTH+1) bits wide and derived from WIDTH; there SHALL be no hard-coded 32.
REQ-028 No sub-module is required; the block SHALL be a single FSM plus datapath consumed by ex (stall request while start_i=1 and ready_o=0).

Verification (WIDTH=32 unless stated)
REQ-029 Unsigned 100/7 -> result_o=0x00000002_0000000E, ready_o rises 33 edges after acceptance.
REQ-030 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-031 5/0 -> ready_o after 2 edges, result_o=0; drop start_i -> FREE, ready_o=0.
REQ-032 annul_i pulsed on the 10th ON cycle -> ready_o never rises, FREE next edge; new request 9/3 accepted immediately -> quotient 3, remainder 0.
REQ-033 rst asserted on the 5th ON cycle -> all outputs 0 next edge; operands changed during ON (no reset) do not alter the result.
REQ-034 WIDTH=8, unsigned 200/3 -> result_o=0x0242, ready_o 9 edges after acceptance.
